// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// State encoding and slice width used by the top and its bench.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell.
// Building block of the 4-bit ripple adder.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/rippe_adder.sv
// 4-bit ripple-carry adder built from fulladder cells.
// One slice of the nibble-serial datapath.
module rippe_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] c;

  assign c[0] = c_i;
  assign c_o  = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_fa
    fulladder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c[i]),
      .s_o (s_o[i]),
      .c_o (c[i+1])
    );
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle, LSB first,
// through a single 4-bit ripple adder with a registered carry.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = WIDTH / NIBBLE_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic            carry_q;

  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;

  rippe_adder u_add (
    .a_i (a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .b_i (b_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .c_i (carry_q),
    .s_o (nib_s),
    .c_o (nib_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= nib_s;
          carry_q <= nib_co;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign ovf       = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH = 16.
// Directed vectors; a monitor pops expected results on each handshake.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  int   accepts = 0;
  int   hshakes = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h, need %0h", nm, got, want);
  endtask

  // Monitor: handshake seen before the edge that completes it.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) accepts++;
    if (rst_n && out_valid && out_ready) begin
      hshakes++;
      if (q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf", 32'(ovf), 32'(e.ov));
      end
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input exp_t e, input bit hold);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd1, 32'd0);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!out_valid && k < 30);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("back_to_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int k;
    int acc0;
    int hs0;
    #12;
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0}, 1'b0);
    wait_valid(k);
    chk("latency", 32'(k), 32'd4);
    wait_idle();

    issue(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}, 1'b0);
    wait_valid(k);
    wait_idle();
    issue(16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}, 1'b0);
    wait_valid(k);
    wait_idle();
    issue(16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}, 1'b0);
    wait_valid(k);
    wait_idle();

    // Operands change after accept; in_valid stays high until DONE.
    acc0 = accepts;
    issue(16'h00FF, 16'h0000, 1'b1, '{16'h0100, 1'b0, 1'b0}, 1'b1);
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b0;
    wait_valid(k);
    in_valid = 1'b0;
    chk("single_accept", 32'(accepts - acc0), 32'd1);
    wait_idle();

    // Backpressure in DONE.
    out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b0, '{16'h3333, 1'b0, 1'b0}, 1'b0);
    wait_valid(k);
    chk("latency_bp", 32'(k), 32'd4);
    hs0 = hshakes;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        #1;
        if (sum !== 16'h3333 || cout !== 1'b0 || ovf !== 1'b0 ||
            in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      chk("stall_stable", 32'(bad), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_handshakes", 32'(hshakes - hs0), 32'd1);

    // Reset in the middle of ADD.
    issue(16'hAAAA, 16'h1111, 1'b1, '{16'hBBBC, 1'b0, 1'b0}, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_sum", 32'(sum), 32'd0);
    q.delete();
    hs0 = hshakes;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_result", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0}, 1'b0);
    wait_valid(k);
    chk("post_reset_latency", 32'(k), 32'd4);
    wait_idle();
    chk("post_reset_handshakes", 32'(hshakes - hs0), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder built around the existing 4-bit ripple-carry adder (`rippe_adder`). It sits directly upstream of that stage and feeds it one 4-bit slice of each operand per cycle, least-significant nibble first. A registered carry links the slices, and the result is assembled into an output register. Operands and results move over valid/ready handshakes, which trades latency for area in wide datapaths.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of 4 and at least 4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: operand transfer request.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input WIDTH: operand A, unsigned or two's complement.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in into bit 0.
- `out_valid` output 1: result registers hold a completed sum.
- `out_ready` input 1: consumer accepts the result.
- `sum` output WIDTH: a + b + cin, modulo 2^WIDTH.
- `cout` output 1: carry out of bit WIDTH-1.
- `ovf` output 1: signed overflow, computed as (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).

## Operation
- NIB = WIDTH/4. The nibble index counter is ceil(log2(NIB)) bits wide, minimum 1.
- The FSM has three states: IDLE, ADD, DONE.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On in_valid && in_ready: latch a, b and cin into operand registers, set the carry register to cin, set idx = 0, and go to ADD.
- ADD:
  - The adder receives a_reg[4*idx+:4], b_reg[4*idx+:4] and the carry register.
  - Each cycle, write S into sum_reg[4*idx+:4], set the carry register to Cout, and increment idx.
  - When idx == NIB-1, go to DONE.
- DONE:
  - out_valid = 1.
  - sum = sum_reg and cout = the carry register.
  - ovf is computed from a_reg, b_reg and sum_reg.
  - On out_valid && out_ready, go to IDLE.
- Operand inputs are sampled only at the accept handshake. Changes after that cycle have no effect.
- in_valid outside IDLE is ignored. No queuing: the upstream holds a, b and cin stable until in_ready is high.
- sum, cout and ovf hold stable throughout DONE regardless of out_ready.
- Outside DONE, sum, cout and ovf are don't-care. They are never X after reset.
- WIDTH = 4 is legal: ADD lasts exactly one cycle.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge):
  - State goes to IDLE.
  - in_ready = 1, out_valid = 0.
  - sum_reg, the carry register, idx and the operand registers are cleared to 0, so sum = 0, cout = 0 and ovf = 0.
- Accept edge = edge 0. ADD occupies the cycles after edges 0 through NIB-1.
- out_valid rises after edge NIB. For the default WIDTH, that is 16 bits = 4 cycles after the accept edge.
- With out_ready held high, the result handshake completes at edge NIB+1, and in_ready is high again after edge NIB+1.
- Maximum throughput is one operation per NIB+2 cycles. Back-to-back overlap is not supported.
- out_ready low in DONE stalls indefinitely, with no loss or change of result.
- rst_n asserted in ADD or DONE aborts the operation immediately. No partial result is ever presented, and out_valid stays 0 until a new operation completes.
- The combinational path is a single 4-bit ripple plus register setup. There is no combinational path from inputs to outputs: in_ready and out_valid decode state only.

## Structure
- Shared package `nibble_adder_pkg` holds:
  - the FSM state encoding (IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2);
  - the constant NIBBLE_W = 4.
- One sub-module instance: the existing 4-bit ripple adder `rippe_adder` (itself built from `fulladder` cells). Sum slice writes use an indexed part-select, not one adder per nibble.
- The top level contains only the FSM, idx counter, operand registers, carry register and sum register.

## Test plan
- a = 0x1234, b = 0x4321, cin = 0 → sum = 0x5555, cout = 0, ovf = 0; out_valid exactly 4 edges after the accept edge.
- a = 0xFFFF, b = 0x0001, cin = 0 → sum = 0x0000, cout = 1, ovf = 0. Checks the carry ripple across all four nibbles.
- a = 0x7FFF, b = 0x0001 → sum = 0x8000, cout = 0, ovf = 1. Then a = 0x8000, b = 0x8000 → sum = 0x0000, cout = 1, ovf = 1.
- a = 0x00FF, b = 0x0000, cin = 1 → sum = 0x0100. Additionally:
  - change a and b on the cycle after accept; the result is unchanged;
  - hold in_valid high throughout; only one accept occurs before DONE.
- Backpressure: out_ready held low 6 cycles in DONE. Required:
  - sum, cout and ovf stay constant;
  - in_ready stays 0;
  - on release, one handshake occurs and in_ready rises the next cycle.
- Reset mid-ADD (after edge 1) → out_valid = 0, in_ready = 1 and sum = 0 immediately (asynchronous). A new operation 0x0001 + 0x0001 then completes with sum = 0x0002.
